// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control sequencer: walks the shared datapath through fetch,
// decode, execute, memory and writeback, with memory wait states and a trap state.
module mips_multicycle_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero_flag,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_write,
   output logic       iord,
   output logic       ir_write,
   output logic       pc_en,
   output logic       reg_write,
   output logic       reg_dest,
   output logic       mem_to_reg,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_control,
   output logic [1:0] pc_src,
   output logic       retired,
   output logic       trap,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BEQ    = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_JMP    = 4'd11,
      S_TRAP   = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b100;

   state_t state_q, state_d;
   logic   pc_write;
   logic   branch;

   // State register with synchronous reset back to FETCH.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; unused encodings fall into TRAP.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXEC;
               OP_BEQ:       state_d = S_BEQ;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JMP;
               default:      state_d = S_TRAP;
            endcase
         end
         S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWB:  state_d = S_FETCH;
         S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
         S_EXEC: begin
            case (funct)
               6'b100000, 6'b100010, 6'b100100,
               6'b100101, 6'b101010: state_d = S_ALUWB;
               default:              state_d = S_TRAP;
            endcase
         end
         S_ALUWB:  state_d = S_FETCH;
         S_BEQ:    state_d = S_FETCH;
         S_ADDIEX: state_d = S_ADDIWB;
         S_ADDIWB: state_d = S_FETCH;
         S_JMP:    state_d = S_FETCH;
         S_TRAP:   state_d = S_TRAP;
         default:  state_d = S_TRAP;
      endcase
   end

   // Moore output decode; reset masks every side-effecting enable immediately.
   always_comb begin
      mem_req     = 1'b0;
      mem_write   = 1'b0;
      iord        = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      branch      = 1'b0;
      reg_write   = 1'b0;
      reg_dest    = 1'b0;
      mem_to_reg  = 1'b0;
      alu_src_a   = 1'b0;
      alu_src_b   = 2'b00;
      alu_control = ALU_ADD;
      pc_src      = 2'b00;
      retired     = 1'b0;
      trap        = 1'b0;
      pc_en       = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_req   = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         S_DECODE: alu_src_b = 2'b11;
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_MEMRD: begin
            mem_req = 1'b1;
            iord    = 1'b1;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            retired    = 1'b1;
         end
         S_MEMWR: begin
            mem_req   = 1'b1;
            mem_write = 1'b1;
            iord      = 1'b1;
            retired   = mem_ready;
         end
         S_EXEC: begin
            alu_src_a = 1'b1;
            case (funct)
               6'b100010: alu_control = ALU_SUB;
               6'b100100: alu_control = ALU_AND;
               6'b100101: alu_control = ALU_OR;
               6'b101010: alu_control = ALU_SLT;
               default:   alu_control = ALU_ADD;
            endcase
         end
         S_ALUWB: begin
            reg_write = 1'b1;
            reg_dest  = 1'b1;
            retired   = 1'b1;
         end
         S_BEQ: begin
            alu_src_a   = 1'b1;
            alu_control = ALU_SUB;
            branch      = 1'b1;
            pc_src      = 2'b01;
            retired     = 1'b1;
         end
         S_ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_ADDIWB: begin
            reg_write = 1'b1;
            retired   = 1'b1;
         end
         S_JMP: begin
            pc_write = 1'b1;
            pc_src   = 2'b10;
            retired  = 1'b1;
         end
         S_TRAP:  trap = 1'b1;
         default: trap = 1'b1;
      endcase
      if (rst) begin
         mem_req   = 1'b0;
         mem_write = 1'b0;
         ir_write  = 1'b0;
         reg_write = 1'b0;
         retired   = 1'b0;
         trap      = 1'b0;
         pc_en     = 1'b0;
      end else begin
         pc_en = pc_write | (branch & zero_flag);
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed plus random bench: per-cycle reference of state and outputs,
// and a per-instruction cycle-count scoreboard.
module tb_mips_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       rst, zero_flag, mem_ready;
   logic [5:0] op, funct;
   logic       mem_req, mem_write, iord, ir_write, pc_en, reg_write, reg_dest;
   logic       mem_to_reg, alu_src_a, retired, trap;
   logic [1:0] alu_src_b, pc_src;
   logic [2:0] alu_control;
   logic [3:0] state;

   int         nchk = 0;
   int         nerr = 0;
   logic [3:0] m_state;
   int         cyc_cnt = 0;
   int         waits = 0;
   int         retire_cnt = 0;
   int         done_cnt = 0;

   mips_multicycle_ctrl dut (
      .clk(clk), .rst(rst), .op(op), .funct(funct), .zero_flag(zero_flag),
      .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write), .iord(iord),
      .ir_write(ir_write), .pc_en(pc_en), .reg_write(reg_write), .reg_dest(reg_dest),
      .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_control(alu_control), .pc_src(pc_src), .retired(retired), .trap(trap),
      .state(state)
   );

   always #5 clk = ~clk;

   wire [17:0] obs_vec = {mem_req, mem_write, iord, ir_write, pc_en, reg_write, reg_dest,
                          mem_to_reg, alu_src_a, alu_src_b, alu_control, pc_src, retired, trap};

   function automatic bit funct_ok(input logic [5:0] f);
      return f == 6'd32 || f == 6'd34 || f == 6'd36 || f == 6'd37 || f == 6'd42;
   endfunction

   function automatic int cpi(input logic [5:0] o);
      case (o)
         6'd35:   return 5;
         6'd43:   return 4;
         6'd0:    return 4;
         6'd8:    return 4;
         6'd4:    return 3;
         6'd2:    return 3;
         default: return -1;
      endcase
   endfunction

   function automatic logic [3:0] next_state(input logic [3:0] s, input logic r, input logic mr);
      if (r) return 4'd0;
      case (s)
         4'd0:  return mr ? 4'd1 : 4'd0;
         4'd1: begin
            if (op == 6'd35 || op == 6'd43) return 4'd2;
            if (op == 6'd0) return 4'd6;
            if (op == 6'd4) return 4'd8;
            if (op == 6'd8) return 4'd9;
            if (op == 6'd2) return 4'd11;
            return 4'd12;
         end
         4'd2:  return (op == 6'd35) ? 4'd3 : 4'd5;
         4'd3:  return mr ? 4'd4 : 4'd3;
         4'd5:  return mr ? 4'd0 : 4'd5;
         4'd6:  return funct_ok(funct) ? 4'd7 : 4'd12;
         4'd9:  return 4'd10;
         4'd12: return 4'd12;
         default: return 4'd0;
      endcase
   endfunction

   function automatic logic [17:0] exp_vec(input logic [3:0] s, input logic r,
                                           input logic mr, input logic zf);
      logic mreq = 0, mw = 0, io = 0, irw = 0, pcw = 0, br = 0, rw = 0, rd = 0;
      logic m2r = 0, sa = 0, ret = 0, tr = 0;
      logic [1:0] sb = 2'd0, ps = 2'd0;
      logic [2:0] ac = 3'd0;
      case (s)
         4'd0:  begin mreq = 1; sb = 2'd1; irw = mr; pcw = mr; end
         4'd1:  sb = 2'd3;
         4'd2:  begin sa = 1; sb = 2'd2; end
         4'd3:  begin mreq = 1; io = 1; end
         4'd4:  begin rw = 1; m2r = 1; ret = 1; end
         4'd5:  begin mreq = 1; mw = 1; io = 1; ret = mr; end
         4'd6:  begin
            sa = 1;
            ac = (funct == 6'd34) ? 3'd1 : (funct == 6'd36) ? 3'd2 :
                 (funct == 6'd37) ? 3'd3 : (funct == 6'd42) ? 3'd4 : 3'd0;
         end
         4'd7:  begin rw = 1; rd = 1; ret = 1; end
         4'd8:  begin sa = 1; ac = 3'd1; br = 1; ps = 2'd1; ret = 1; end
         4'd9:  begin sa = 1; sb = 2'd2; end
         4'd10: begin rw = 1; ret = 1; end
         4'd11: begin pcw = 1; ps = 2'd2; ret = 1; end
         default: tr = 1;
      endcase
      if (r) begin mreq = 0; mw = 0; irw = 0; pcw = 0; br = 0; rw = 0; ret = 0; tr = 0; end
      return {mreq, mw, io, irw, pcw | (br & zf), rw, rd, m2r, sa, sb, ac, ps, ret, tr};
   endfunction

   // One clock cycle: drive inputs, check outputs against the model, advance.
   task automatic cyc(input logic r, input logic mr, input logic zf);
      logic [17:0] e;
      rst = r; mem_ready = mr; zero_flag = zf;
      #1;
      e = exp_vec(m_state, r, mr, zf);
      nchk++;
      assert (state === m_state) else begin
         nerr++; $error("FAIL state obs=%0d exp=%0d", state, m_state);
      end
      nchk++;
      assert (obs_vec === e) else begin
         nerr++; $error("FAIL outputs st=%0d obs=%b exp=%b", m_state, obs_vec, e);
      end
      if (r) begin
         cyc_cnt = 0; waits = 0;
      end else begin
         cyc_cnt++;
         if (!mr && (m_state == 4'd0 || m_state == 4'd3 || m_state == 4'd5)) waits++;
         if (e[1]) begin
            done_cnt++;
            nchk++;
            assert (cyc_cnt == cpi(op) + waits) else begin
               nerr++; $error("FAIL cpi op=%0d obs=%0d exp=%0d", op, cyc_cnt, cpi(op) + waits);
            end
            cyc_cnt = 0; waits = 0;
         end
      end
      m_state = next_state(m_state, r, mr);
      @(posedge clk); #1;
   endtask

   always @(negedge clk) if (retired === 1'b1) retire_cnt++;

   initial begin
      rst = 1'b1; op = 6'd0; funct = 6'd0; mem_ready = 1'b0; zero_flag = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      m_state = 4'd0;
      cyc(1, 1, 0);
      // lw, no waits
      op = 6'd35;
      repeat (5) cyc(0, 1, 0);
      // R-type sub with 3 fetch wait cycles
      op = 6'd0; funct = 6'd34;
      repeat (3) cyc(0, 0, 0);
      repeat (4) cyc(0, 1, 0);
      // beq taken then not taken
      op = 6'd4;
      repeat (3) cyc(0, 1, 1);
      repeat (3) cyc(0, 1, 0);
      // sw with 2 wait cycles in MEMWR
      op = 6'd43;
      repeat (3) cyc(0, 1, 0);
      cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 1, 0);
      // addi and j
      op = 6'd8;  repeat (4) cyc(0, 1, 0);
      op = 6'd2;  repeat (3) cyc(0, 1, 1);
      // illegal op, then illegal funct
      op = 6'd63;
      repeat (2) cyc(0, 1, 0);
      repeat (3) cyc(0, 1, 1);
      cyc(1, 1, 0);
      op = 6'd0; funct = 6'd7;
      repeat (3) cyc(0, 1, 1);
      repeat (3) cyc(0, 0, 1);
      cyc(1, 0, 0);
      // reset during a MEMRD wait, then a clean lw
      op = 6'd35;
      repeat (3) cyc(0, 1, 0);
      cyc(0, 0, 0);
      cyc(1, 0, 0);
      repeat (5) cyc(0, 1, 0);
      nchk++;
      assert (retire_cnt == done_cnt) else begin
         nerr++; $error("FAIL retire_count obs=%0d exp=%0d", retire_cnt, done_cnt);
      end
      // random instruction stream
      for (int i = 0; i < 3000; i++) begin
         logic r;
         if (m_state == 4'd0) begin
            case ($urandom_range(0, 7))
               0: op = 6'd35;
               1: op = 6'd43;
               2: op = 6'd0;
               3: op = 6'd4;
               4: op = 6'd8;
               5: op = 6'd2;
               6: op = 6'd0;
               default: op = 6'($urandom_range(0, 63));
            endcase
            funct = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) :
                    ($urandom_range(0, 1) == 0) ? 6'd32 : 6'd34 + 6'($urandom_range(0, 3)) * 6'd2;
            if (funct == 6'd40) funct = 6'd42;
            if (funct == 6'd38) funct = 6'd37;
         end
         r = (m_state == 4'd12) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 63) == 0);
         cyc(r, 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)));
      end
      nchk++;
      assert (retire_cnt == done_cnt) else begin
         nerr++; $error("FAIL retire_total obs=%0d exp=%0d", retire_cnt, done_cnt);
      end
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
